ex_operand_buffer: RTL and testbench

//  Decode-to-execute buffer feeding the ALU. A 2-entry skid buffer with valid/ready handshakes
//  and a synchronous flush. It holds decoded operands and applies write-back bypass to the

---
 rtl/ex_operand_buffer_if.sv | 40 ++++
 rtl/ex_operand_buffer.sv | 116 +++++++++++
 tb/tb_ex_operand_buffer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_buffer_if.sv
// Handshake bundle between decode, the operand buffer, write-back and the ALU.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface ex_operand_buffer_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_src1;
  logic [XLEN-1:0]   in_src2;
  logic [XLEN-1:0]   in_imm;
  logic              in_sel_imm;
  logic [RIDX_W-1:0] in_rs1_idx;
  logic [RIDX_W-1:0] in_rs2_idx;
  logic [3:0]        in_func;
  logic [RIDX_W-1:0] in_rd;
  logic              in_wen;
  logic              wb_wen;
  logic [RIDX_W-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1;
  logic [XLEN-1:0]   out_rs2;
  logic [3:0]        out_func;
  logic [RIDX_W-1:0] out_rd;
  logic              out_wen;

  modport slave (
    input  in_valid, in_src1, in_src2, in_imm, in_sel_imm, in_rs1_idx, in_rs2_idx,
           in_func, in_rd, in_wen, wb_wen, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_func, out_rd, out_wen
  );

  modport master (
    output in_valid, in_src1, in_src2, in_imm, in_sel_imm, in_rs1_idx, in_rs2_idx,
           in_func, in_rd, in_wen, wb_wen, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_func, out_rd, out_wen
  );
endinterface

// File: rtl/ex_operand_buffer.sv
// Decode-to-execute 2-entry skid buffer with write-back bypass on captured and held operands.
// The main entry drives the ALU directly; the skid entry absorbs one beat of backpressure.
module ex_operand_buffer #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  ex_operand_buffer_if.slave      bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   imm;
    logic              sel_imm;
    logic [RIDX_W-1:0] rs1_idx;
    logic [RIDX_W-1:0] rs2_idx;
    logic [3:0]        func;
    logic [RIDX_W-1:0] rd;
    logic              wen;
  } entry_t;

  // x0 is hardwired zero, so a write-back to index 0 never forwards.
  function automatic entry_t bypass(input entry_t e, input logic wen,
                                    input logic [RIDX_W-1:0] rd,
                                    input logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (wen && (rd != '0) && (rd == e.rs1_idx)) r.src1 = data;
    if (wen && (rd != '0) && (rd == e.rs2_idx)) r.src2 = data;
    return r;
  endfunction

  state_t state;
  entry_t main_e;
  entry_t skid_e;
  entry_t in_raw;
  entry_t in_e;
  entry_t main_byp;
  entry_t skid_byp;
  logic   in_fire;
  logic   out_fire;

  assign bus.in_ready  = (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_comb begin
    in_raw         = '0;
    in_raw.src1    = bus.in_src1;
    in_raw.src2    = bus.in_src2;
    in_raw.imm     = bus.in_imm;
    in_raw.sel_imm = bus.in_sel_imm;
    in_raw.rs1_idx = bus.in_rs1_idx;
    in_raw.rs2_idx = bus.in_rs2_idx;
    in_raw.func    = bus.in_func;
    in_raw.rd      = bus.in_rd;
    in_raw.wen     = bus.in_wen;
    in_e     = bypass(in_raw, bus.wb_wen, bus.wb_rd, bus.wb_data);
    main_byp = bypass(main_e, bus.wb_wen, bus.wb_rd, bus.wb_data);
    skid_byp = bypass(skid_e, bus.wb_wen, bus.wb_rd, bus.wb_data);
  end

  // Held entries take the bypassed value every cycle unless overwritten below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_e <= '0;
      skid_e <= '0;
    end else begin
      main_e <= main_byp;
      skid_e <= skid_byp;
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_e <= in_e;
              state  <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_e <= in_e;
            end else if (in_fire) begin
              skid_e <= in_e;
              state  <= TWO;
            end else if (out_fire) begin
              state  <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_e <= skid_byp;
              state  <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign bus.out_rs1  = main_e.src1;
  assign bus.out_rs2  = main_e.sel_imm ? main_e.imm : main_e.src2;
  assign bus.out_func = main_e.func;
  assign bus.out_rd   = main_e.rd;
  assign bus.out_wen  = main_e.wen;

endmodule

// File: tb/tb_ex_operand_buffer.sv
// Directed bench for ex_operand_buffer: vector table for streaming/backpressure/immediate,
// hand sequences for bypass, flush and asynchronous reset.
module tb_ex_operand_buffer;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  ex_operand_buffer_if #(.XLEN(32), .RIDX_W(5)) bus ();

  ex_operand_buffer #(.XLEN(32), .RIDX_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] imm;
    logic        sel;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        e_vld;
    logic        e_rdy;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [3:0]  e_func;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic iv, logic ordy, logic [31:0] s1, logic [31:0] s2,
                               logic [31:0] imm, logic sel, logic [3:0] func, logic [4:0] rd,
                               logic ev, logic er, logic [31:0] e1, logic [31:0] e2,
                               logic [3:0] ef, logic [4:0] erd);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.s1 = s1; v.s2 = s2; v.imm = imm; v.sel = sel;
    v.func = func; v.rd = rd; v.e_vld = ev; v.e_rdy = er; v.e_rs1 = e1; v.e_rs2 = e2;
    v.e_func = ef; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] imm, input logic sel, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [3:0] func, input logic [4:0] rd);
    bus.in_valid   = iv;
    bus.in_src1    = s1;
    bus.in_src2    = s2;
    bus.in_imm     = imm;
    bus.in_sel_imm = sel;
    bus.in_rs1_idx = r1;
    bus.in_rs2_idx = r2;
    bus.in_func    = func;
    bus.in_rd      = rd;
    bus.in_wen     = 1'b1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic set_wb(input logic wen, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_wen  = wen;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'h0);

    // Power-on reset state
    #3;
    chk("rst0_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst0_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst0_out_rs1",   bus.out_rs1, 32'h0);
    chk("rst0_out_wen",   {31'b0, bus.out_wen},   32'd0);
    #9 rst_n = 1'b1;
    cyc();

    // T2 stream: eight back-to-back entries, each visible one cycle after acceptance
    for (int i = 0; i < 8; i++)
      vecs.push_back(mkv(1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 32'h0, 1'b0, 4'(i), 5'(i + 1),
                         1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 4'(i), 5'(i + 1)));
    vecs.push_back(mkv(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0,
                       1'b0, 1'b1, 32'h107, 32'h207, 4'd7, 5'd8));
    // T3 backpressure: A, B accepted, C refused until the head drains
    vecs.push_back(mkv(1'b1, 1'b0, 32'hA1, 32'hA2, 32'h0, 1'b0, 4'd1, 5'd10,
                       1'b1, 1'b1, 32'hA1, 32'hA2, 4'd1, 5'd10));
    vecs.push_back(mkv(1'b1, 1'b0, 32'hB1, 32'hB2, 32'h0, 1'b0, 4'd2, 5'd11,
                       1'b1, 1'b0, 32'hA1, 32'hA2, 4'd1, 5'd10));
    vecs.push_back(mkv(1'b1, 1'b0, 32'hC1, 32'hC2, 32'h0, 1'b0, 4'd3, 5'd12,
                       1'b1, 1'b0, 32'hA1, 32'hA2, 4'd1, 5'd10));
    vecs.push_back(mkv(1'b1, 1'b1, 32'hC1, 32'hC2, 32'h0, 1'b0, 4'd3, 5'd12,
                       1'b1, 1'b1, 32'hB1, 32'hB2, 4'd2, 5'd11));
    vecs.push_back(mkv(1'b1, 1'b1, 32'hC1, 32'hC2, 32'h0, 1'b0, 4'd3, 5'd12,
                       1'b1, 1'b1, 32'hC1, 32'hC2, 4'd3, 5'd12));
    vecs.push_back(mkv(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0,
                       1'b0, 1'b1, 32'hC1, 32'hC2, 4'd3, 5'd12));
    // T5 immediate operand selected onto rs2
    vecs.push_back(mkv(1'b1, 1'b0, 32'h3, 32'h7, 32'hFFFF_FFF0, 1'b1, 4'd0, 5'd1,
                       1'b1, 1'b1, 32'h3, 32'hFFFF_FFF0, 4'd0, 5'd1));
    vecs.push_back(mkv(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0, 5'd0,
                       1'b0, 1'b1, 32'h3, 32'hFFFF_FFF0, 4'd0, 5'd1));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].s1, vecs[i].s2, vecs[i].imm, vecs[i].sel, 5'd0, 5'd0,
            vecs[i].func, vecs[i].rd);
      bus.out_ready = vecs[i].ordy;
      cyc();
      chk($sformatf("vec%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].e_vld});
      chk($sformatf("vec%0d_in_ready", i),  {31'b0, bus.in_ready},  {31'b0, vecs[i].e_rdy});
      chk($sformatf("vec%0d_out_rs1", i),   bus.out_rs1, vecs[i].e_rs1);
      chk($sformatf("vec%0d_out_rs2", i),   bus.out_rs2, vecs[i].e_rs2);
      chk($sformatf("vec%0d_out_func", i),  {28'b0, bus.out_func}, {28'b0, vecs[i].e_func});
      chk($sformatf("vec%0d_out_rd", i),    {27'b0, bus.out_rd},   {27'b0, vecs[i].e_rd});
    end

    // T4 hold bypass on rs1=5, then write-back to x0 leaves it alone
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 5'd5, 5'd0, 4'd0, 5'd1);
    cyc();
    chk("byp_before", bus.out_rs1, 32'h11);
    bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd5, 32'hDEAD);
    cyc();
    chk("byp_hold_rs1", bus.out_rs1, 32'hDEAD);
    set_wb(1'b1, 5'd0, 32'hBEEF);
    cyc();
    chk("byp_wbrd0_unchanged", bus.out_rs1, 32'hDEAD);
    set_wb(1'b0, 5'd0, 32'h0);
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd0, 5'd1);
    cyc();
    bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd0, 32'hBEEF);
    cyc();
    chk("byp_x0_never", bus.out_rs1, 32'h11);

    // Bypass applied at capture time on rs2
    set_wb(1'b1, 5'd7, 32'h77);
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h2, 32'h0, 1'b0, 5'd0, 5'd7, 4'd0, 5'd1);
    cyc();
    chk("byp_capture_rs2", bus.out_rs2, 32'h77);
    chk("byp_capture_rs1", bus.out_rs1, 32'h1);

    // Skid entry bypass, including the cycle it moves into main
    set_wb(1'b0, 5'd0, 32'h0);
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1, 32'h0, 32'h0, 1'b0, 5'd3, 5'd0, 4'd0, 5'd1);
    cyc();
    drive(1'b1, 32'h2, 32'h0, 32'h0, 1'b0, 5'd4, 5'd0, 4'd0, 5'd2);
    cyc();
    bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd4, 32'h44);
    cyc();
    chk("byp_skid_main_untouched", bus.out_rs1, 32'h1);
    set_wb(1'b1, 5'd4, 32'h55);
    bus.out_ready = 1'b1;
    cyc();
    chk("byp_skid_to_main", bus.out_rs1, 32'h55);
    chk("byp_skid_to_main_rd", {27'b0, bus.out_rd}, 32'd2);
    set_wb(1'b0, 5'd0, 32'h0);

    // T6 flush from TWO with a same-cycle offer
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd1, 5'd1);
    cyc();
    drive(1'b1, 32'hB, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd2, 5'd2);
    cyc();
    chk("flush_pre_in_ready", {31'b0, bus.in_ready}, 32'd0);
    drive(1'b1, 32'hDD, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd3, 5'd3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_in_ready",  {31'b0, bus.in_ready},  32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("flush_no_emit%0d", k), {31'b0, bus.out_valid}, 32'd0);
    end
    // Flush from ONE while both fires would otherwise happen
    drive(1'b1, 32'hE, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd4, 5'd4);
    cyc();
    drive(1'b1, 32'hF, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd5, 5'd5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_one_out_valid", {31'b0, bus.out_valid}, 32'd0);
    drive(1'b1, 32'h66, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 4'd6, 5'd6);
    cyc();
    chk("flush_recover_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("flush_recover_rs1",   bus.out_rs1, 32'h66);

    // T1 asynchronous reset with two entries held
    drain();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h91, 32'h92, 32'h0, 1'b0, 5'd0, 5'd0, 4'd9, 5'd9);
    cyc();
    drive(1'b1, 32'h93, 32'h94, 32'h0, 1'b0, 5'd0, 5'd0, 4'd10, 5'd10);
    cyc();
    bus.in_valid = 1'b0;
    chk("rst_pre_in_ready", {31'b0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_rs1",   bus.out_rs1, 32'h0);
    chk("rst_out_rs2",   bus.out_rs2, 32'h0);
    chk("rst_out_func",  {28'b0, bus.out_func}, 32'd0);
    chk("rst_out_rd",    {27'b0, bus.out_rd},   32'd0);
    chk("rst_out_wen",   {31'b0, bus.out_wen},  32'd0);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    chk("rst_after_out_valid", {31'b0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
